// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one RAM port between a CPU's instruction-fetch and data
//            read/write requests. A registered grant FSM gives data requests
//            priority; completion, wait and load data are combinational in
//            the RAM's ACCESS cycle.
// Options  : MEM_ARB_TIMEOUT_EN - when defined, a service that sees no ACCESS
//            within TIMEOUT_CYCLES service cycles is abandoned with a
//            one-cycle timeout pulse. When undefined, timeout is tied low
//            and a service waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int WORD_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ram_err,
    output logic              timeout
);

    localparam logic [1:0] c_RAM_ACCESS = 2'b10;
    localparam logic [1:0] c_RAM_ERROR  = 2'b11;

    // A service needs at least one non-final cycle for the limit to mean anything.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DSERV = 2'd1,
        ST_ISERV = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] iload_q, iload_d;
    logic [WORD_W-1:0] dload_q, dload_d;

    logic w_d_req;
    logic w_svc_active;
    logic w_access;
    logic w_expired;

    assign w_d_req  = dREN | dWEN;
    assign w_access = (ramstate == c_RAM_ACCESS);
    // Granted requester still asking: anything else in a service state is an abort.
    assign w_svc_active = ((state_q == ST_DSERV) & w_d_req) |
                          ((state_q == ST_ISERV) & iREN);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] svc_cnt_q, svc_cnt_d;

    assign w_expired = (svc_cnt_q == c_CNT_LAST);

    // Count service cycles without ACCESS; any exit from service clears it.
    always_comb begin
        svc_cnt_d = '0;
        if (w_svc_active && !w_access && !w_expired) begin
            svc_cnt_d = svc_cnt_q + c_CNT_ONE;
        end
    end

    // Service-cycle counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            svc_cnt_q <= '0;
        end else begin
            svc_cnt_q <= svc_cnt_d;
        end
    end
`else
    assign w_expired = 1'b0;
`endif

    assign timeout = w_svc_active & ~w_access & w_expired;

    // State and held-load registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            state_q <= state_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
        end
    end

    // Grant decisions, RAM port drive and requester handshakes.
    always_comb begin
        state_d  = state_q;
        iload_d  = iload_q;
        dload_d  = dload_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = iload_q;
        dload    = dload_q;
        ram_err  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_d_req) begin
                    state_d = ST_DSERV;
                end else if (iREN) begin
                    state_d = ST_ISERV;
                end
            end
            ST_DSERV: begin
                if (!w_d_req) begin
                    state_d = ST_IDLE;
                end else begin
                    ramaddr = daddr;
                    ram_err = (ramstate == c_RAM_ERROR);
                    if (!timeout) begin
                        // A combined read+write request is serviced as a write.
                        ramWEN   = dWEN;
                        ramREN   = ~dWEN;
                        ramstore = dWEN ? dstore : '0;
                    end
                    if (w_access) begin
                        dwait   = 1'b0;
                        state_d = ST_IDLE;
                        if (!dWEN) begin
                            dload   = ramload;
                            dload_d = ramload;
                        end
                    end else if (timeout) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ISERV: begin
                if (!iREN) begin
                    state_d = ST_IDLE;
                end else begin
                    ramaddr = iaddr;
                    ram_err = (ramstate == c_RAM_ERROR);
                    ramREN  = ~timeout;
                    if (w_access) begin
                        iwait   = 1'b0;
                        iload   = ramload;
                        iload_d = ramload;
                        state_d = ST_IDLE;
                    end else if (timeout) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. Directed scenarios and
//            randomized traffic are compared each cycle against a
//            transaction-level model of who owns the RAM port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;
    localparam int TMO    = 8;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam logic [1:0] FREE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] ACCESS = 2'b10;
    localparam logic [1:0] ERROR  = 2'b11;

    logic              CLK = 1'b0;
    logic              RST;
    logic              iREN, dREN, dWEN;
    logic [ADDR_W-1:0] iaddr, daddr;
    logic [WORD_W-1:0] dstore, ramload;
    logic [1:0]        ramstate;
    logic              iwait, dwait, ramREN, ramWEN, ram_err, timeout;
    logic [WORD_W-1:0] iload, dload, ramstore;
    logic [ADDR_W-1:0] ramaddr;

    mem_arbiter #(
        .WORD_W         (WORD_W),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .ram_err  (ram_err),
        .timeout  (timeout)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: which requester owns the port, how long it has been served,
    // and the last word each requester loaded.
    int          owner;        // 0 none, 1 data, 2 instruction
    int          svc_cycles;
    logic [31:0] i_hold, d_hold;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner      = 0;
        svc_cycles = 0;
        i_hold     = '0;
        d_hold     = '0;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_ramREN"},   ramREN,   0);
        check({pfx, "_ramWEN"},   ramWEN,   0);
        check({pfx, "_ramaddr"},  ramaddr,  0);
        check({pfx, "_ramstore"}, ramstore, 0);
        check({pfx, "_iwait"},    iwait,    1);
        check({pfx, "_dwait"},    dwait,    1);
        check({pfx, "_iload"},    iload,    0);
        check({pfx, "_dload"},    dload,    0);
        check({pfx, "_ram_err"},  ram_err,  0);
        check({pfx, "_timeout"},  timeout,  0);
    endtask

    // One clock cycle: drive inputs after the falling edge, compare mid-cycle,
    // then advance the model to what the next rising edge must produce.
    task automatic step(input bit dr, input bit dw, input bit ir, input logic [1:0] rs,
                        input logic [31:0] da, input logic [31:0] ia,
                        input logic [31:0] ds, input logic [31:0] rl);
        bit          dreq, keep, done, tmo;
        bit          e_ren, e_wen, e_iw, e_dw, e_err;
        logic [31:0] e_addr, e_store;
        int          nxt;
        @(negedge CLK);
        dREN = dr; dWEN = dw; iREN = ir; ramstate = rs;
        daddr = da; iaddr = ia; dstore = ds; ramload = rl;
        #1;
        dreq = dr | dw;
        done = 0; tmo = 0; e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1; e_err = 0;
        e_addr = '0; e_store = '0;
        nxt = owner;
        if (owner == 0) begin
            nxt = dreq ? 1 : (ir ? 2 : 0);
        end else begin
            keep = (owner == 1) ? dreq : ir;
            if (!keep) begin
                nxt = 0;
            end else begin
                done  = (rs == ACCESS);
                tmo   = TMO_EN && !done && (svc_cycles == TMO - 1);
                e_err = (rs == ERROR);
                if (owner == 1) begin
                    e_addr  = da;
                    e_store = ds;
                    e_wen   = !tmo && dw;
                    e_ren   = !tmo && !dw;
                    e_dw    = !done;
                end else begin
                    e_addr = ia;
                    e_ren  = !tmo;
                    e_iw   = !done;
                end
                nxt = (done || tmo) ? 0 : owner;
            end
        end
        check("ramREN",  ramREN,  e_ren);
        check("ramWEN",  ramWEN,  e_wen);
        check("iwait",   iwait,   e_iw);
        check("dwait",   dwait,   e_dw);
        check("ram_err", ram_err, e_err);
        check("timeout", timeout, tmo);
        if (e_ren || e_wen) check("ramaddr", ramaddr, e_addr);
        if (e_wen)          check("ramstore", ramstore, e_store);
        check("iload", iload, (owner == 2 && done) ? rl : i_hold);
        if (owner == 1 && done && !dw) check("dload_new", dload, rl);
        else if (!(owner == 1 && done)) check("dload_hold", dload, d_hold);
        if (done && owner == 2) i_hold = rl;
        if (done && owner == 1 && !dw) d_hold = rl;
        svc_cycles = (nxt != 0 && nxt == owner) ? svc_cycles + 1 : 0;
        owner = nxt;
    endtask

    task automatic idle_inputs();
        dREN = 0; dWEN = 0; iREN = 0; ramstate = FREE;
        daddr = '0; iaddr = '0; dstore = '0; ramload = '0;
    endtask

    // Reset pulse placed mid-cycle, away from any clock edge.
    task automatic async_reset(input string pfx);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check_reset_values(pfx);
        model_reset();
        idle_inputs();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          r_dr, r_dw, r_ir;
        int          pick;
        logic [1:0]  r_rs;

        RST = 1'b1;
        idle_inputs();
        model_reset();
        #3;
        check_reset_values("rst");
        @(negedge CLK);
        RST = 1'b0;

        // Fetch with ACCESS two cycles after grant.
        step(0, 0, 1, FREE,   0, 32'h40, 0, 0);
        step(0, 0, 1, BUSY,   0, 32'h40, 0, 0);
        step(0, 0, 1, ACCESS, 0, 32'h40, 0, 32'hDEADBEEF);
        check("t1_iload", iload, 32'hDEADBEEF);
        step(0, 0, 0, FREE,   0, 0, 0, 0);

        // Simultaneous data and fetch request: data first, fetch after one idle cycle.
        step(1, 0, 1, FREE,   32'h80, 32'h40, 0, 0);
        step(1, 0, 1, BUSY,   32'h80, 32'h40, 0, 0);
        step(1, 0, 1, ACCESS, 32'h80, 32'h40, 0, 32'h0000_1111);
        step(0, 0, 1, FREE,   0, 32'h40, 0, 0);
        step(0, 0, 1, BUSY,   0, 32'h40, 0, 0);
        step(0, 0, 1, ACCESS, 0, 32'h40, 0, 32'h2222_0000);
        step(0, 0, 0, FREE,   0, 0, 0, 0);

        // Write, including a combined read+write that must act as a write.
        step(0, 1, 0, FREE,   32'h100, 0, 32'h12345678, 0);
        step(0, 1, 0, BUSY,   32'h100, 0, 32'h12345678, 0);
        step(0, 1, 0, ACCESS, 32'h100, 0, 32'h12345678, 32'h5555_5555);
        step(1, 1, 0, FREE,   32'h104, 0, 32'hCAFEF00D, 0);
        step(1, 1, 0, ACCESS, 32'h104, 0, 32'hCAFEF00D, 32'h6666_6666);
        step(0, 0, 0, FREE,   0, 0, 0, 0);

        // Data read dropped while BUSY.
        step(1, 0, 0, FREE,   32'h200, 0, 0, 0);
        step(1, 0, 0, BUSY,   32'h200, 0, 0, 0);
        step(0, 0, 0, BUSY,   32'h200, 0, 0, 0);
        step(0, 0, 0, FREE,   0, 0, 0, 0);

        // ERROR retries then completion.
        step(0, 0, 1, FREE,   0, 32'h300, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 1, ERROR, 0, 32'h300, 0, 0);
        step(0, 0, 1, ACCESS, 0, 32'h300, 0, 32'hA5A5_5A5A);
        step(0, 0, 0, FREE,   0, 0, 0, 0);

        // RAM stuck BUSY past the timeout limit.
        step(1, 0, 0, FREE, 32'h400, 0, 0, 0);
        for (int k = 0; k < TMO + 4; k++) step(1, 0, 0, BUSY, 32'h400, 0, 0, 0);
        step(0, 0, 0, FREE, 0, 0, 0, 0);

        // Reset in the middle of a fetch service.
        step(0, 0, 1, FREE, 0, 32'h500, 0, 0);
        step(0, 0, 1, BUSY, 0, 32'h500, 0, 0);
        async_reset("midrst");

        // Randomized traffic with sticky request lines.
        r_dr = 0; r_dw = 0; r_ir = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) r_dr = ~r_dr;
            if ($urandom_range(0, 11) == 0) r_dw = ~r_dw;
            if ($urandom_range(0, 5) == 0) r_ir = ~r_ir;
            pick = $urandom_range(0, 99);
            if (pick < 30)      r_rs = ACCESS;
            else if (pick < 70) r_rs = BUSY;
            else if (pick < 85) r_rs = FREE;
            else                r_rs = ERROR;
            step(r_dr, r_dw, r_ir, r_rs, $urandom, $urandom, $urandom, $urandom);
            if (c == 1500) async_reset("rndrst");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
